// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer
// Drains the 17-bit pixel/marker FWFT queue, tracks frame and row structure,
// collects pixels into BURST_WORDS-word bursts and writes them through a
// command/data burst interface into one of two frame buffers. The buffer that
// holds the most recent complete frame is published for the display side.
module frame_buffer_writer #(
    parameter int FRAME_WIDTH  = 480,
    parameter int FRAME_HEIGHT = 272,
    parameter int BURST_WORDS  = 16,
    parameter int ADDR_WIDTH   = 21,
    parameter int BASE_ADDR    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  queue_empty,
    input  logic [16:0]           queue_data,
    output logic                  queue_rd_en,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic                  mem_data_valid,
    input  logic                  mem_data_ready,
    output logic [15:0]           mem_data,
    output logic                  frame_done,
    output logic                  write_buffer,
    output logic                  display_buffer,
    output logic                  frame_valid,
    output logic                  sync_error
);

    localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
    localparam int COL_W = $clog2(FRAME_WIDTH + 1);
    localparam int IDX_W = $clog2(BURST_WORDS);

    localparam logic [ADDR_WIDTH-1:0] BUF0_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BUF1_BASE = ADDR_WIDTH'(BASE_ADDR + FRAME_WIDTH * FRAME_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] ROW_PITCH = ADDR_WIDTH'(FRAME_WIDTH);
    localparam logic [ROW_W-1:0]      ROWS      = ROW_W'(FRAME_HEIGHT);
    localparam logic [COL_W-1:0]      COLS      = COL_W'(FRAME_WIDTH);
    localparam logic [COL_W-1:0]      COL_STEP  = COL_W'(BURST_WORDS);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(BURST_WORDS - 1);

    typedef enum logic [2:0] {
        ST_WAIT_FRAME = 3'd0,
        ST_WAIT_ROW   = 3'd1,
        ST_FILL       = 3'd2,
        ST_CMD        = 3'd3,
        ST_DATA       = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
    logic             write_buffer_q, write_buffer_d;
    logic             display_buffer_q, display_buffer_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_error_q, sync_error_d;
    logic             buf_we;
    logic [15:0]      burst_mem_q [BURST_WORDS];

    // Head-word classification; any marker that is neither frame start nor
    // row start behaves as a frame end.
    logic             is_pixel;
    logic             is_frame_start;
    logic             is_row_start;
    logic [COL_W-1:0] col_next;

    assign is_pixel       = ~queue_data[16];
    assign is_frame_start = (queue_data == 17'h1_0000);
    assign is_row_start   = (queue_data == 17'h1_0001);
    assign col_next       = col_cnt_q + COL_STEP;

    // Burst start address: buffer base plus row/column offset, modulo 2^ADDR_WIDTH.
    always_comb begin
        mem_cmd_addr = (write_buffer_q ? BUF1_BASE : BUF0_BASE)
                     + (ADDR_WIDTH'(row_cnt_q) * ROW_PITCH)
                     + ADDR_WIDTH'(col_cnt_q);
    end

    assign mem_cmd_valid  = (state_q == ST_CMD);
    assign mem_data_valid = (state_q == ST_DATA);
    assign mem_data       = burst_mem_q[beat_idx_q];
    assign frame_done     = frame_done_q;
    assign sync_error     = sync_error_q;
    assign write_buffer   = write_buffer_q;
    assign display_buffer = display_buffer_q;
    assign frame_valid    = frame_valid_q;

    // Next-state, counter and pop decisions for the stream parser / burst writer.
    always_comb begin
        state_d          = state_q;
        row_cnt_d        = row_cnt_q;
        col_cnt_d        = col_cnt_q;
        fill_idx_d       = fill_idx_q;
        beat_idx_d       = beat_idx_q;
        write_buffer_d   = write_buffer_q;
        display_buffer_d = display_buffer_q;
        frame_valid_d    = frame_valid_q;
        frame_done_d     = 1'b0;
        sync_error_d     = 1'b0;
        queue_rd_en      = 1'b0;
        buf_we           = 1'b0;

        case (state_q)
            ST_WAIT_FRAME: begin
                // Everything ahead of a frame start is silently discarded.
                queue_rd_en = ~queue_empty;
                if (!queue_empty && is_frame_start) begin
                    row_cnt_d = '0;
                    state_d   = ST_WAIT_ROW;
                end else begin
                    state_d = ST_WAIT_FRAME;
                end
            end

            ST_WAIT_ROW: begin
                queue_rd_en = ~queue_empty;
                if (queue_empty) begin
                    state_d = ST_WAIT_ROW;
                end else if (is_row_start) begin
                    if (row_cnt_q < ROWS) begin
                        col_cnt_d  = '0;
                        fill_idx_d = '0;
                        state_d    = ST_FILL;
                    end else begin
                        sync_error_d = 1'b1;
                        state_d      = ST_WAIT_FRAME;
                    end
                end else if (is_frame_start) begin
                    sync_error_d = 1'b1;
                    row_cnt_d    = '0;
                end else if (is_pixel) begin
                    sync_error_d = 1'b1;
                end else begin
                    // Frame end: only a frame with every row present is published.
                    if (row_cnt_q == ROWS) begin
                        frame_done_d     = 1'b1;
                        display_buffer_d = write_buffer_q;
                        write_buffer_d   = ~write_buffer_q;
                        frame_valid_d    = 1'b1;
                    end else begin
                        sync_error_d = 1'b1;
                    end
                    state_d = ST_WAIT_FRAME;
                end
            end

            ST_FILL: begin
                if (queue_empty) begin
                    state_d = ST_FILL;
                end else if (is_pixel) begin
                    queue_rd_en = 1'b1;
                    buf_we      = 1'b1;
                    if (fill_idx_q == IDX_LAST) begin
                        fill_idx_d = '0;
                        state_d    = ST_CMD;
                    end else begin
                        fill_idx_d = fill_idx_q + 1'b1;
                    end
                end else begin
                    // Marker inside a row: leave it queued so WAIT_ROW reparses it;
                    // a row start then rewrites the same row index from column 0.
                    sync_error_d = 1'b1;
                    fill_idx_d   = '0;
                    state_d      = ST_WAIT_ROW;
                end
            end

            ST_CMD: begin
                if (mem_cmd_ready) begin
                    beat_idx_d = '0;
                    state_d    = ST_DATA;
                end else begin
                    state_d = ST_CMD;
                end
            end

            ST_DATA: begin
                if (mem_data_ready) begin
                    if (beat_idx_q == IDX_LAST) begin
                        beat_idx_d = '0;
                        col_cnt_d  = col_next;
                        if (col_next == COLS) begin
                            row_cnt_d = row_cnt_q + 1'b1;
                            state_d   = ST_WAIT_ROW;
                        end else begin
                            fill_idx_d = '0;
                            state_d    = ST_FILL;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            default: begin
                state_d = ST_WAIT_FRAME;
            end
        endcase
    end

    // State, counters and published buffer flags with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_WAIT_FRAME;
            row_cnt_q        <= '0;
            col_cnt_q        <= '0;
            fill_idx_q       <= '0;
            beat_idx_q       <= '0;
            write_buffer_q   <= 1'b0;
            display_buffer_q <= 1'b0;
            frame_valid_q    <= 1'b0;
            frame_done_q     <= 1'b0;
            sync_error_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            row_cnt_q        <= row_cnt_d;
            col_cnt_q        <= col_cnt_d;
            fill_idx_q       <= fill_idx_d;
            beat_idx_q       <= beat_idx_d;
            write_buffer_q   <= write_buffer_d;
            display_buffer_q <= display_buffer_d;
            frame_valid_q    <= frame_valid_d;
            frame_done_q     <= frame_done_d;
            sync_error_q     <= sync_error_d;
        end
    end

    // Burst staging storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            burst_mem_q[fill_idx_q] <= queue_data[15:0];
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer (32x2 frame, 16-word bursts).
// A word-level reference model predicts bursts, pulses and buffer flags.
module tb_frame_buffer_writer;

    localparam int W    = 32;
    localparam int H    = 2;
    localparam int BW   = 16;
    localparam int AW   = 21;
    localparam int BASE = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          queue_empty = 1'b1;
    logic [16:0]   queue_data = 17'h0;
    logic          queue_rd_en;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready = 1'b1;
    logic [AW-1:0] mem_cmd_addr;
    logic          mem_data_valid;
    logic          mem_data_ready = 1'b1;
    logic [15:0]   mem_data;
    logic          frame_done, write_buffer, display_buffer, frame_valid, sync_error;

    frame_buffer_writer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .BURST_WORDS(BW),
                          .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .queue_empty(queue_empty), .queue_data(queue_data),
        .queue_rd_en(queue_rd_en), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr(mem_cmd_addr), .mem_data_valid(mem_data_valid),
        .mem_data_ready(mem_data_ready), .mem_data(mem_data), .frame_done(frame_done),
        .write_buffer(write_buffer), .display_buffer(display_buffer),
        .frame_valid(frame_valid), .sync_error(sync_error));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Source queue, memory-side modes and captured traffic
    logic [16:0]   q[$];
    int            cmd_mode = 0;  // 0 always ready, 1 random, 2 held low, 3 toggle
    int            data_mode = 0;
    bit            gap_en = 0;
    bit            pop_pend = 0, cmd_pend = 0, beat_pend = 0;
    logic [AW-1:0] cmd_pend_addr, prev_addr;
    logic [15:0]   beat_pend_data, prev_data;
    bit            prev_cmd_stall = 0, prev_data_stall = 0;
    logic [AW-1:0] cap_addr[$];
    logic [15:0]   cap_data[$];
    int            done_cnt = 0, sync_cnt = 0, viol = 0, beats_in_burst = 0;

    // Reference model state
    int            m_mode = 0, m_row = 0, m_col = 0;  // m_mode: 0 hunting frame, 1 between rows, 2 in row
    logic [15:0]   m_pend[$];
    bit            m_wb = 0, m_db = 0, m_fv = 0;
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];
    int            exp_done = 0, exp_sync = 0;
    logic [16:0]   stim[$];

    // Negedge driver: retire last edge's handshakes, drive inputs, sample outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (pop_pend && q.size() > 0) void'(q.pop_front());
            if (cmd_pend) begin cap_addr.push_back(cmd_pend_addr); beats_in_burst = 0; end
            if (beat_pend) begin cap_data.push_back(beat_pend_data); beats_in_burst++; end
            case (cmd_mode)
                1: mem_cmd_ready = 1'($urandom_range(0, 1));
                2: mem_cmd_ready = 1'b0;
                3: mem_cmd_ready = ~mem_cmd_ready;
                default: mem_cmd_ready = 1'b1;
            endcase
            case (data_mode)
                1: mem_data_ready = 1'($urandom_range(0, 1));
                2: mem_data_ready = 1'b0;
                3: mem_data_ready = ~mem_data_ready;
                default: mem_data_ready = 1'b1;
            endcase
            queue_empty = (q.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
            queue_data  = (q.size() > 0) ? q[0] : 17'h0;
            #1;
            if (!reset) begin
                if (frame_done) done_cnt++;
                if (sync_error) sync_cnt++;
                if ((mem_cmd_valid || mem_data_valid) && queue_rd_en) viol++;
                if (prev_cmd_stall && (!mem_cmd_valid || mem_cmd_addr !== prev_addr)) viol++;
                if (prev_data_stall && (!mem_data_valid || mem_data !== prev_data)) viol++;
            end
            prev_cmd_stall  = mem_cmd_valid && !mem_cmd_ready;
            prev_data_stall = mem_data_valid && !mem_data_ready;
            prev_addr       = mem_cmd_addr;
            prev_data       = mem_data;
            pop_pend        = queue_rd_en && !queue_empty;
            cmd_pend        = mem_cmd_valid && mem_cmd_ready;
            cmd_pend_addr   = mem_cmd_addr;
            beat_pend       = mem_data_valid && mem_data_ready;
            beat_pend_data  = mem_data;
        end
    end

    // Reference: walk the word stream by frame/row structure, emitting a burst
    // whenever BW pixels of a row have been collected.
    task automatic model_word(input logic [16:0] w);
        bit again;
        int a;
        again = 1;
        while (again) begin
            again = 0;
            if (m_mode == 0) begin
                if (w == 17'h1_0000) begin m_row = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (w == 17'h1_0001) begin
                    if (m_row < H) begin m_col = 0; m_pend.delete(); m_mode = 2; end
                    else begin exp_sync++; m_mode = 0; end
                end else if (w == 17'h1_0000) begin
                    exp_sync++; m_row = 0;
                end else if (w[16] == 1'b0) begin
                    exp_sync++;
                end else begin
                    if (m_row == H) begin exp_done++; m_db = m_wb; m_wb = !m_wb; m_fv = 1; end
                    else exp_sync++;
                    m_mode = 0;
                end
            end else begin
                if (w[16] == 1'b0) begin
                    m_pend.push_back(w[15:0]);
                    if (m_pend.size() == BW) begin
                        a = BASE + (m_wb ? W * H : 0) + m_row * W + m_col;
                        exp_addr.push_back(AW'(a));
                        foreach (m_pend[i]) exp_data.push_back(m_pend[i]);
                        m_pend.delete();
                        m_col += BW;
                        if (m_col == W) begin m_row++; m_mode = 1; end
                    end
                end else begin
                    exp_sync++; m_pend.delete(); m_mode = 1; again = 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_row = 0; m_col = 0; m_pend.delete();
        m_wb = 0; m_db = 0; m_fv = 0;
    endtask

    task automatic clear_logs();
        cap_addr.delete(); cap_data.delete(); exp_addr.delete(); exp_data.delete();
        done_cnt = 0; sync_cnt = 0; exp_done = 0; exp_sync = 0; viol = 0;
    endtask

    task automatic add_row(input int npx, input bit rnd);
        stim.push_back(17'h1_0001);
        for (int p = 0; p < npx; p++) stim.push_back(rnd ? {1'b0, 16'($urandom)} : {1'b0, 16'(p)});
    endtask

    task automatic add_clean_frame();
        stim.push_back(17'h1_0000);
        for (int r = 0; r < H; r++) add_row(W, 1'b0);
        stim.push_back(17'h1_FFFF);
    endtask

    task automatic send();
        foreach (stim[i]) begin model_word(stim[i]); q.push_back(stim[i]); end
        stim.delete();
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        bit ok;
        quiet = 0; ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #2;
            if (q.size() == 0 && !pop_pend && !mem_cmd_valid && !mem_data_valid) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin ok = 1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got busy after 4000 cycles, required idle", tag);
        end
    endtask

    function automatic int addr_diff();
        if (cap_addr.size() != exp_addr.size()) return -2;
        foreach (cap_addr[i]) if (cap_addr[i] !== exp_addr[i]) return i;
        return -1;
    endfunction

    function automatic int data_diff();
        if (cap_data.size() != exp_data.size()) return -2;
        foreach (cap_data[i]) if (cap_data[i] !== exp_data[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        tests++;
        if ({mem_cmd_valid, mem_data_valid, queue_rd_en} !== 3'b000) begin
            fails++; $display("FAIL reset_valids: got %b, required 000", {mem_cmd_valid, mem_data_valid, queue_rd_en});
        end
        tests++;
        if ({frame_done, sync_error, write_buffer, display_buffer, frame_valid} !== 5'b00000) begin
            fails++; $display("FAIL reset_flags: got %b, required 00000",
                              {frame_done, sync_error, write_buffer, display_buffer, frame_valid});
        end
        @(negedge clk); #3;
        reset = 1'b0;
        model_reset(); clear_logs();
    endtask

    task automatic test_clean_frame();
        int d;
        clear_logs();
        add_clean_frame(); send(); wait_idle("clean1");
        tests++;
        if ({write_buffer, display_buffer, frame_valid} !== 3'b101 || done_cnt !== 1) begin
            fails++; $display("FAIL clean1_flags: got wb/db/fv=%b done=%0d, required 101 done=1",
                              {write_buffer, display_buffer, frame_valid}, done_cnt);
        end
        add_clean_frame(); send(); wait_idle("clean2");
        tests++;
        if ({write_buffer, display_buffer, frame_valid} !== 3'b011 || done_cnt !== 2) begin
            fails++; $display("FAIL clean2_flags: got wb/db/fv=%b done=%0d, required 011 done=2",
                              {write_buffer, display_buffer, frame_valid}, done_cnt);
        end
        tests++;
        if (cap_addr.size() !== 8) begin
            fails++; $display("FAIL clean_burst_count: got %0d, required 8", cap_addr.size());
        end else begin
            tests++;
            if (cap_addr[1] !== 21'd16 || cap_addr[4] !== 21'd64 || cap_addr[7] !== 21'd112) begin
                fails++; $display("FAIL clean_addr_const: got %0d/%0d/%0d, required 16/64/112",
                                  cap_addr[1], cap_addr[4], cap_addr[7]);
            end
        end
        d = data_diff(); tests++;
        if (d !== -1) begin
            fails++; $display("FAIL clean_data: first diff %0d (got %0d beats, required %0d)", d, cap_data.size(), exp_data.size());
        end
    endtask

    task automatic test_backpressure();
        int d;
        bit seen;
        logic [AW-1:0] held;
        clear_logs();
        cmd_mode = 2;
        add_clean_frame(); send();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (mem_cmd_valid) begin seen = 1; break; end
        end
        held = exp_addr.size() > 0 ? exp_addr[0] : '0;
        repeat (10) @(negedge clk);
        #2;
        tests++;
        if (!seen || mem_cmd_valid !== 1'b1 || mem_cmd_addr !== held || cap_addr.size() !== 0) begin
            fails++; $display("FAIL bp_cmd_hold: got valid=%b addr=%0d accepted=%0d, required valid=1 addr=%0d accepted=0",
                              mem_cmd_valid, mem_cmd_addr, cap_addr.size(), held);
        end
        cmd_mode = 0; data_mode = 3;
        wait_idle("bp");
        data_mode = 0;
        d = addr_diff(); tests++;
        if (d !== -1) begin
            fails++; $display("FAIL bp_addr: first diff %0d (got %0d bursts, required %0d)", d, cap_addr.size(), exp_addr.size());
        end
        d = data_diff(); tests++;
        if (d !== -1) begin
            fails++; $display("FAIL bp_data: first diff %0d (got %0d beats, required %0d)", d, cap_data.size(), exp_data.size());
        end
        tests++;
        if (viol !== 0) begin
            fails++; $display("FAIL bp_stability: got %0d violations, required 0", viol);
        end
    endtask

    task automatic test_short_row();
        int d;
        logic [AW-1:0] base;
        clear_logs();
        base = m_wb ? AW'(W * H) : AW'(BASE);
        stim.push_back(17'h1_0000);
        add_row(20, 1'b1); add_row(W, 1'b1); add_row(W, 1'b1);
        stim.push_back(17'h1_FFFF);
        send(); wait_idle("short");
        tests++;
        if (sync_cnt !== 1 || done_cnt !== exp_done) begin
            fails++; $display("FAIL short_pulses: got sync=%0d done=%0d, required sync=1 done=%0d", sync_cnt, done_cnt, exp_done);
        end
        tests++;
        if (cap_addr.size() < 2) begin
            fails++; $display("FAIL short_restart: got %0d bursts, required at least 2", cap_addr.size());
        end else if (cap_addr[0] !== base || cap_addr[1] !== base) begin
            fails++; $display("FAIL short_restart: got %0d,%0d, required %0d,%0d", cap_addr[0], cap_addr[1], base, base);
        end
        d = addr_diff() + 10 * (data_diff() + 2); tests++;
        if (d !== 9) begin
            fails++; $display("FAIL short_traffic: got diff code %0d, required 9", d);
        end
    endtask

    task automatic test_pre_frame_garbage();
        int d;
        clear_logs();
        stim.push_back(17'h0_0123); stim.push_back(17'h1_0001); stim.push_back(17'h1_FFFF);
        send();
        repeat (20) @(negedge clk);
        #2;
        tests++;
        if (cap_addr.size() !== 0 || sync_cnt !== 0 || q.size() !== 0) begin
            fails++; $display("FAIL garbage_quiet: got bursts=%0d sync=%0d left=%0d, required 0/0/0",
                              cap_addr.size(), sync_cnt, q.size());
        end
        add_clean_frame(); send(); wait_idle("garbage");
        d = addr_diff(); tests++;
        if (d !== -1 || done_cnt !== 1 || sync_cnt !== 0) begin
            fails++; $display("FAIL garbage_frame: got diff=%0d done=%0d sync=%0d, required -1/1/0", d, done_cnt, sync_cnt);
        end
    endtask

    task automatic test_missing_row();
        clear_logs();
        stim.push_back(17'h1_0000); add_row(W, 1'b1); stim.push_back(17'h1_FFFF);
        send(); wait_idle("missing");
        tests++;
        if (sync_cnt !== 1 || done_cnt !== 0) begin
            fails++; $display("FAIL missing_pulses: got sync=%0d done=%0d, required 1/0", sync_cnt, done_cnt);
        end
        tests++;
        if ({write_buffer, display_buffer, frame_valid} !== {m_wb, m_db, m_fv}) begin
            fails++; $display("FAIL missing_flags: got %b, required %b",
                              {write_buffer, display_buffer, frame_valid}, {m_wb, m_db, m_fv});
        end
    endtask

    task automatic test_random();
        int d, nrows;
        clear_logs();
        gap_en = 1; cmd_mode = 1; data_mode = 1;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 2) == 0) stim.push_back(17'($urandom));
            stim.push_back(17'h1_0000);
            nrows = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : H;
            for (int r = 0; r < nrows; r++)
                add_row(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : W, 1'b1);
            stim.push_back(($urandom_range(0, 5) == 0) ? 17'h1_2345 : 17'h1_FFFF);
        end
        send(); wait_idle("random");
        gap_en = 0; cmd_mode = 0; data_mode = 0;
        d = addr_diff(); tests++;
        if (d !== -1) begin
            fails++; $display("FAIL random_addr: first diff %0d (got %0d, required %0d)", d, cap_addr.size(), exp_addr.size());
        end
        d = data_diff(); tests++;
        if (d !== -1) begin
            fails++; $display("FAIL random_data: first diff %0d (got %0d, required %0d)", d, cap_data.size(), exp_data.size());
        end
        tests++;
        if (done_cnt !== exp_done || sync_cnt !== exp_sync || viol !== 0) begin
            fails++; $display("FAIL random_pulses: got done=%0d sync=%0d viol=%0d, required %0d/%0d/0",
                              done_cnt, sync_cnt, viol, exp_done, exp_sync);
        end
        tests++;
        if ({write_buffer, display_buffer, frame_valid} !== {m_wb, m_db, m_fv}) begin
            fails++; $display("FAIL random_flags: got %b, required %b",
                              {write_buffer, display_buffer, frame_valid}, {m_wb, m_db, m_fv});
        end
    endtask

    task automatic test_reset_mid_burst();
        int d;
        bit seen;
        clear_logs();
        add_clean_frame(); send();
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #2;
            if (mem_data_valid && beats_in_burst == 5) begin seen = 1; break; end
        end
        tests++;
        if (!seen || mem_data !== 16'h0005) begin
            fails++; $display("FAIL midrst_beat5: got seen=%0d data=%h, required 1/0005", seen, mem_data);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({mem_data_valid, mem_cmd_valid} !== 2'b00) begin
            fails++; $display("FAIL midrst_async: got %b, required 00", {mem_data_valid, mem_cmd_valid});
        end
        q.delete(); pop_pend = 0; cmd_pend = 0; beat_pend = 0;
        prev_cmd_stall = 0; prev_data_stall = 0; beats_in_burst = 0;
        model_reset(); clear_logs();
        repeat (2) @(negedge clk);
        #3 reset = 1'b0;
        add_clean_frame(); send(); wait_idle("midrst");
        tests++;
        if (cap_addr.size() < 1 || cap_addr[0] !== 21'd0) begin
            fails++; $display("FAIL midrst_addr0: got %0d bursts first=%0d, required first=0",
                              cap_addr.size(), cap_addr.size() > 0 ? cap_addr[0] : '1);
        end
        d = addr_diff() + 10 * (data_diff() + 2); tests++;
        if (d !== 9 || {write_buffer, display_buffer, frame_valid} !== 3'b101) begin
            fails++; $display("FAIL midrst_frame: got diff code %0d flags %b, required 9 and 101",
                              d, {write_buffer, display_buffer, frame_valid});
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_backpressure();
        test_short_row();
        test_pre_frame_garbage();
        test_missing_row();
        test_random();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion by 900000, required completion");
        $fatal(1);
    end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
Downstream consumer of the 17-bit pixel/marker queue fed by the pattern generator or the camera capture path. It pops the FWFT queue, parses frame/row markers, gathers pixels into BURST_WORDS-word bursts and writes them to a double-buffered frame store through a command/data burst interface. It publishes which buffer holds the last complete frame for the display reader.

Parameters:
FRAME_WIDTH, 480, pixels per row; must be a multiple of BURST_WORDS.
FRAME_HEIGHT, 272, rows per frame.
BURST_WORDS, 16, 16-bit words per memory burst (power of 2, 2..64).
ADDR_WIDTH, 21, word address width.
BASE_ADDR, 0, word address of buffer 0; buffer 1 = BASE_ADDR + FRAME_WIDTH*FRAME_HEIGHT.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
queue_empty  in  1  source FIFO empty.
queue_data  in  17  FWFT head word, valid when !queue_empty. Decode: 0x10000 = frame start, 0x10001 = row start, 0x1FFFF = frame end, bit16=0 = pixel (bits 15:0 RGB565); other bit16=1 values are treated as frame end.
queue_rd_en  out  1  pop head word (combinational).
mem_cmd_valid  out  1  burst write command pending.
mem_cmd_ready  in  1  command accepted when valid&ready.
mem_cmd_addr  out  ADDR_WIDTH  burst start word address.
mem_data_valid  out  1  write beat valid.
mem_data_ready  in  1  beat accepted when valid&ready.
mem_data  out  16  write beat data.
frame_done  out  1  one-cycle pulse on completed frame.
write_buffer  out  1  buffer currently being written.
display_buffer  out  1  buffer holding last complete frame.
frame_valid  out  1  at least one complete frame stored.
sync_error  out  1  one-cycle pulse on stream protocol violation.

Behaviour:
- Reset (async, immediate): state WAIT_FRAME; row_cnt, col_cnt, fill_idx, beat_idx = 0; all outputs 0 (write_buffer=0, display_buffer=0, frame_valid=0); burst buffer contents don't-care.
- queue_rd_en = !queue_empty & (pop condition of current state); never asserted in CMD/DATA.
- WAIT_FRAME: pop every word; discard all until 0x10000 -> row_cnt=0, WAIT_ROW. No sync_error here.
- WAIT_ROW: pop head. 0x10001: if row_cnt<FRAME_HEIGHT -> col_cnt=0, fill_idx=0, FILL; else sync_error, WAIT_FRAME. Frame end: if row_cnt==FRAME_HEIGHT -> frame_done, display_buffer<=write_buffer, write_buffer toggles, frame_valid<=1, WAIT_FRAME; else sync_error, WAIT_FRAME, buffers unchanged. 0x10000: sync_error, row_cnt=0, stay. Pixel: discard, sync_error.
- FILL: pixel at head -> pop, buf[fill_idx]=data[15:0]; on fill_idx==BURST_WORDS-1 go CMD (fill_idx=0). Marker at head -> NOT popped, sync_error, partial burst discarded, row_cnt unchanged, WAIT_ROW (marker reprocessed; 0x10001 restarts same row index).
- CMD: mem_cmd_valid=1, addr = base(write_buffer) + row_cnt*FRAME_WIDTH + col_cnt, held stable until ready; on handshake -> DATA, beat_idx=0. First cmd can assert the cycle after the last fill pop.
- DATA: mem_data_valid=1, mem_data=buf[beat_idx]; beat_idx++ per handshake. On last beat: col_cnt+=BURST_WORDS; if new col_cnt==FRAME_WIDTH -> row_cnt++, WAIT_ROW; else FILL. No overlap of fill with DATA.
- Address arithmetic: full ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH.
- Backpressure: any number of ready-low cycles; no queue pops, outputs stable.
- Reset mid-burst: valids drop immediately; after release resynchronises on next 0x10000.

Test Plan:
(FRAME_WIDTH=32, FRAME_HEIGHT=2, BURST_WORDS=16, BASE_ADDR=0)
1. Clean frame: 0x10000, {0x10001, 32 pixels 0x0000..0x001F}x2, 0x1FFFF -> cmd addrs 0,16,32,48, beats equal pixel values in order; frame_done pulse; write_buffer=1, display_buffer=0, frame_valid=1. Second frame -> addrs 64,80,96,112; write_buffer=0, display_buffer=1.
2. Backpressure: mem_cmd_ready low 10 cycles then mem_data_ready toggling -> queue_rd_en=0 throughout, addr/data stable, all 16 beats delivered once.
3. Short row: 0x10001, 20 pixels, 0x10001 -> one burst at addr 0, sync_error pulse, 4 pixels dropped; next row rewritten starting at addr 0.
4. Pre-frame garbage: 0x00123, 0x10001, 0x1FFFF then clean frame -> garbage popped, no mem activity, no sync_error, frame completes as test 1.
5. Missing row: 0x10000, one full row, 0x1FFFF -> sync_error, no frame_done, write_buffer/frame_valid unchanged.
6. Reset asserted during DATA beat 5 -> mem_data_valid=0 asynchronously; after release clean frame writes from addr 0 with write_buffer=0.
